// File: rtl/seq_div_16_bit_pkg.sv
// Shared definitions for the ALU divider slice.
//   div_state_e   : divider control states (IDLE, RUN, FIX)
//   DIV_W         : operand/result width
//   DIV_CNT_W     : iteration counter width (must hold DIV_W)
//   DIV_ZERO_QUOT : quotient returned for a zero divisor
package alu_div_pkg;
  localparam int unsigned DIV_W     = 16;
  localparam int unsigned DIV_CNT_W = 5;
  localparam logic [DIV_W-1:0] DIV_ZERO_QUOT = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } div_state_e;
endpackage

// File: rtl/seq_div_16_bit_sub.sv
// sub_16_bit: combinational 16-bit subtract, diff = a - b, computed as
// a + ~b + 1 in the same form as the ALU adders.
//   a, b   : minuend, subtrahend
//   diff   : a - b modulo 2^16
//   borrow : 1 when b > a (inverted carry-out)
module sub_16_bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] diff,
  output logic        borrow
);
  logic [16:0] sum;

  always_comb begin
    sum = {1'b0, a} + {1'b0, ~b} + 17'd1;
  end

  assign diff   = sum[15:0];
  assign borrow = ~sum[16];
endmodule

// File: rtl/seq_div_16_bit.sv
// seq_div_16_bit: iterative restoring divider, one quotient bit per clock,
// fixed 17-cycle latency from accepted start to the done pulse.
// Build option: define SEQ_DIV_SIGNED_EN to honour signed_op (two's-complement
// divide truncating toward zero); otherwise every divide is unsigned.
//   clk, rst_n         : clock, asynchronous active-low reset
//   start              : divide request, sampled only in IDLE
//   signed_op          : 1 = signed divide (only with SEQ_DIV_SIGNED_EN)
//   dividend, divisor  : operands, sampled with start
//   busy               : operation in progress
//   done               : one-cycle result-valid pulse
//   quotient, remainder: results, held until the next completion
//   div_by_zero        : last operation had a zero divisor
module seq_div_16_bit
  import alu_div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_W,
  parameter int unsigned CNT_W = DIV_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] shift_rem;
  logic [WIDTH-1:0] trial_diff;
  logic             trial_borrow;
  logic             take;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic             dvs_zero;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  // The shifted partial remainder is 17 bits wide; its top bit is rem_q[15].
  // When that bit is set the value exceeds any divisor, so the subtract
  // always succeeds and the low 16 bits of the difference are exact.
  assign shift_rem = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
  assign take      = rem_q[WIDTH-1] | ~trial_borrow;

  sub_16_bit u_trial (
    .a      (shift_rem),
    .b      (dvs_q),
    .diff   (trial_diff),
    .borrow (trial_borrow)
  );

`ifdef SEQ_DIV_SIGNED_EN
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] dvd_neg, dvs_neg, quo_neg, rem_neg;
  logic             dvd_nz, dvs_nz, quo_nz, rem_nz;

  // 0 - x negators; the borrow of 0 - x is exactly (x != 0), used as the
  // divisor zero test and to gate negation (negating zero is a no-op).
  sub_16_bit u_dvd_neg (.a('0), .b(dividend), .diff(dvd_neg), .borrow(dvd_nz));
  sub_16_bit u_dvs_neg (.a('0), .b(divisor),  .diff(dvs_neg), .borrow(dvs_nz));
  sub_16_bit u_quo_neg (.a('0), .b(quo_q),    .diff(quo_neg), .borrow(quo_nz));
  sub_16_bit u_rem_neg (.a('0), .b(rem_q),    .diff(rem_neg), .borrow(rem_nz));

  assign dvd_mag  = (signed_op & dividend[WIDTH-1] & dvd_nz) ? dvd_neg : dividend;
  assign dvs_mag  = (signed_op & divisor[WIDTH-1]  & dvs_nz) ? dvs_neg : divisor;
  assign dvs_zero = ~dvs_nz;
  assign quo_fix  = (neg_quo_q & quo_nz) ? quo_neg : quo_q;
  assign rem_fix  = (neg_rem_q & rem_nz) ? rem_neg : rem_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  always_comb begin
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    if (state_q == IDLE && start) begin
      neg_quo_d = signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
      neg_rem_d = signed_op & dividend[WIDTH-1];
    end
  end
`else
  logic unused_signed_op;
  assign unused_signed_op = signed_op;
  assign dvd_mag  = dividend;
  assign dvs_mag  = divisor;
  assign dvs_zero = (divisor == '0);
  assign quo_fix  = quo_q;
  assign rem_fix  = rem_q;
`endif

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    zero_d      = zero_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    done_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          count_d = '0;
          rem_d   = '0;
          quo_d   = dvd_mag;
          dvs_d   = dvs_mag;
          zero_d  = dvs_zero;
        end
      end
      RUN: begin
        rem_d   = take ? trial_diff : shift_rem;
        quo_d   = {quo_q[WIDTH-2:0], take};
        count_d = count_q + CNT_W'(1);
        if (count_q == CNT_W'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        // A zero divisor leaves the dividend magnitude in rem_q, so the
        // normal remainder sign fix already restores the raw dividend.
        quotient_d  = zero_q ? DIV_ZERO_QUOT : quo_fix;
        remainder_d = rem_fix;
        dbz_d       = zero_q;
        done_d      = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      zero_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      zero_q      <= zero_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      done_q      <= done_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_div_16_bit.sv
// Self-checking bench for seq_div_16_bit; compile with the same
// SEQ_DIV_SIGNED_EN setting as the RTL.
module tb_seq_div_16_bit;
`ifdef SEQ_DIV_SIGNED_EN
  localparam bit SIGNED_BUILD = 1'b1;
`else
  localparam bit SIGNED_BUILD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        signed_op = 1'b0;
  logic [15:0] dividend = '0;
  logic [15:0] divisor = '0;
  logic        busy, done, div_by_zero;
  logic [15:0] quotient, remainder;

  int checks = 0;
  int errors = 0;

  seq_div_16_bit #(.WIDTH(16), .CNT_W(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .signed_op   (signed_op),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  // Reference: plain integer division from the arithmetic rules.
  function automatic void ref_div(input logic s, input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] q, output logic [15:0] r, output logic dz);
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    dz = 1'b0;
    if (b == 16'h0000) begin
      q = 16'hFFFF; r = a; dz = 1'b1;
    end else if (s && SIGNED_BUILD) begin
      if (sa == -32768 && sb == -1) begin
        q = 16'h8000; r = 16'h0000;
      end else begin
        q = 16'(sa / sb);
        r = 16'(sa % sb);
      end
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Start one divide and wait (bounded) for done; lat counts edges after the accepting edge.
  task automatic do_div(input logic s, input logic [15:0] a, input logic [15:0] b,
                        output logic [15:0] q, output logic [15:0] r, output logic dz,
                        output int lat);
    @(negedge clk);
    start = 1'b1; signed_op = s; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0; signed_op = 1'($urandom); dividend = 16'($urandom); divisor = 16'($urandom);
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    q = quotient; r = remainder; dz = div_by_zero;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++;
    if ({quotient, remainder, div_by_zero} !== 33'd0) begin
      errors++;
      $display("FAIL reset_outputs got q=%h r=%h dz=%b want 0", quotient, remainder, div_by_zero);
    end
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        s;
    logic [15:0] a, b, q, r;
    logic        dz;
  } vec_t;

  task automatic test_directed();
    vec_t v[6];
    logic [15:0] q, r;
    logic dz;
    int lat;
    v[0] = '{1'b0, 16'd100, 16'd7, 16'd14, 16'd2, 1'b0};
    v[1] = '{1'b1, 16'hFFF9, 16'h0002, SIGNED_BUILD ? 16'hFFFD : 16'h7FFC,
             SIGNED_BUILD ? 16'hFFFF : 16'h0001, 1'b0};
    v[2] = '{1'b0, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1};
    v[3] = '{1'b1, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1};
    v[4] = '{1'b1, 16'h8000, 16'hFFFF, SIGNED_BUILD ? 16'h8000 : 16'h0000,
             SIGNED_BUILD ? 16'h0000 : 16'h8000, 1'b0};
    v[5] = '{1'b0, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0};
    foreach (v[i]) begin
      do_div(v[i].s, v[i].a, v[i].b, q, r, dz, lat);
      checks++;
      if (lat !== 17) begin errors++; $display("FAIL dir%0d_latency got %0d want 17", i, lat); end
      checks++;
      if ({q, r, dz} !== {v[i].q, v[i].r, v[i].dz}) begin
        errors++;
        $display("FAIL dir%0d_result got q=%h r=%h dz=%b want q=%h r=%h dz=%b",
                 i, q, r, dz, v[i].q, v[i].r, v[i].dz);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL dir%0d_done_width got done=%b want 0", i, done); end
    end
  endtask

  task automatic test_random();
    logic [15:0] a, b, q, r, eq, er;
    logic s, dz, edz;
    int lat;
    for (int n = 0; n < 40; n++) begin
      s = 1'($urandom);
      a = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
      case ($urandom_range(0, 7))
        0:       b = 16'h0000;
        1:       b = 16'hFFFF;
        2, 3:    b = 16'($urandom_range(1, 15));
        default: b = 16'($urandom);
      endcase
      ref_div(s, a, b, eq, er, edz);
      do_div(s, a, b, q, r, dz, lat);
      checks++;
      if (lat !== 17 || {q, r, dz} !== {eq, er, edz}) begin
        errors++;
        $display("FAIL rand%0d s=%b %h/%h got q=%h r=%h dz=%b lat=%0d want q=%h r=%h dz=%b lat=17",
                 n, s, a, b, q, r, dz, lat, eq, er, edz);
      end
    end
  endtask

  task automatic test_start_during_run();
    logic [15:0] held_q, held_r, eq, er;
    logic edz, held_ok;
    int lat;
    held_q = quotient;
    held_r = remainder;
    ref_div(1'b0, 16'd1000, 16'd33, eq, er, edz);
    @(negedge clk);
    start = 1'b1; signed_op = 1'b0; dividend = 16'd1000; divisor = 16'd33;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL run_busy got %b want 1", busy); end
    lat = 0;
    held_ok = 1'b1;
    while (done !== 1'b1 && lat < 40) begin
      if (quotient !== held_q || remainder !== held_r) held_ok = 1'b0;
      if (lat == 5) begin
        start = 1'b1; dividend = 16'd9; divisor = 16'd2;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    checks++;
    if (held_ok !== 1'b1) begin errors++; $display("FAIL run_hold outputs changed during RUN got 0 want 1"); end
    checks++;
    if (lat !== 17 || {quotient, remainder, div_by_zero} !== {eq, er, edz}) begin
      errors++;
      $display("FAIL run_ignore_start got q=%h r=%h lat=%0d want q=%h r=%h lat=17",
               quotient, remainder, lat, eq, er);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL run_no_relaunch got busy=%b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] eq1, er1, eq2, er2;
    logic edz1, edz2;
    int lat;
    ref_div(1'b0, 16'd60000, 16'd7, eq1, er1, edz1);
    ref_div(1'b1, 16'hC000, 16'd5, eq2, er2, edz2);
    @(negedge clk);
    start = 1'b1; signed_op = 1'b0; dividend = 16'd60000; divisor = 16'd7;
    @(negedge clk);
    signed_op = 1'b1; dividend = 16'hC000; divisor = 16'd5;
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 17 || {quotient, remainder, div_by_zero} !== {eq1, er1, edz1}) begin
      errors++;
      $display("FAIL b2b_first got q=%h r=%h lat=%0d want q=%h r=%h lat=17", quotient, remainder, lat, eq1, er1);
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_launch got done=%b busy=%b want done=0 busy=1", done, busy);
    end
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 17 || {quotient, remainder, div_by_zero} !== {eq2, er2, edz2}) begin
      errors++;
      $display("FAIL b2b_second got q=%h r=%h lat=%0d want q=%h r=%h lat=17", quotient, remainder, lat, eq2, er2);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] q, r;
    logic dz, saw_done;
    int lat;
    @(negedge clk);
    start = 1'b1; signed_op = 1'b0; dividend = 16'h1234; divisor = 16'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 35'd0) begin
      errors++;
      $display("FAIL midreset_clear got busy=%b done=%b q=%h r=%h dz=%b want 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done !== 1'b0) saw_done = 1'b1;
    end
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (done !== 1'b0) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) begin errors++; $display("FAIL midreset_no_done got done pulse want none"); end
    do_div(1'b0, 16'd50, 16'd5, q, r, dz, lat);
    checks++;
    if (lat !== 17 || {q, r, dz} !== {16'd10, 16'd0, 1'b0}) begin
      errors++;
      $display("FAIL midreset_after got q=%0d r=%0d dz=%b lat=%0d want q=10 r=0 dz=0 lat=17", q, r, dz, lat);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_during_run();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
